// File: rtl/tdc_wb_master.sv
// Wishbone classic-cycle initiator for the opentdc_wb slave port.
// It takes one command at a time (a single write or an incrementing read
// burst), runs one non-pipelined bus beat per response, and aborts a beat
// whose ack never arrives.
module tdc_wb_master #(
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 64   // legal range 1..255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  // command stream
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [31:0]      cmd_adr_i,
  input  logic [31:0]      cmd_dat_i,
  input  logic [3:0]       cmd_sel_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  // response stream
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_dat_o,
  output logic             rsp_last_o,
  output logic             rsp_timeout_o,
  // Wishbone master port
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // The counter compares against the value it holds in the last allowed
  // strobe cycle, so stb stays high for exactly TIMEOUT_CYC cycles.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic             run_q, run_d;     // keeps cmd_ready low until the first edge after reset
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [3:0]       sel_q, sel_d;
  logic [LEN_W-1:0] beats_q, beats_d; // beats remaining after the current one
  logic [7:0]       cnt_q, cnt_d;     // strobe cycles spent on the current beat
  logic [31:0]      rdat_q, rdat_d;
  logic             tmo_q, tmo_d;

  logic             rsp_last;

  assign rsp_last = (beats_q == '0) || tmo_q;

  // Next-state and datapath: every beat goes BUS -> RESP, then back to BUS
  // for the next address or to IDLE once the last response is taken.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block
    // can leave a signal unassigned and infer a latch.
    state_d = state_q;
    run_d   = 1'b1;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    rdat_d  = rdat_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_we_i ? cmd_dat_i : 32'h0;
          sel_d   = cmd_sel_i;
          beats_d = cmd_we_i ? '0 : cmd_len_i;
          cnt_d   = 8'h0;
          rdat_d  = 32'h0;
          tmo_d   = 1'b0;
          state_d = BUS;
        end
      end
      BUS: begin
        cnt_d = cnt_q + 8'd1;
        // An ack in the same cycle as the limit still completes the beat.
        if (wbm_ack_i) begin
          rdat_d  = we_q ? 32'h0 : wbm_dat_i;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdat_d  = 32'h0;
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          if (rsp_last) begin
            state_d = IDLE;
          end else begin
            adr_d   = adr_q + 32'd4;   // wraps modulo 2^32
            beats_d = beats_q - LEN_W'(1);
            cnt_d   = 8'h0;
            state_d = BUS;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops the bus and empties the pipeline at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: registers update with <= so every flop samples the pre-edge
    // values of the others regardless of statement order.
    if (wb_rst_i) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'h0;
      dat_q   <= 32'h0;
      sel_q   <= 4'h0;
      beats_q <= '0;
      cnt_q   <= 8'h0;
      rdat_q  <= 32'h0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      rdat_q  <= rdat_d;
      tmo_q   <= tmo_d;
    end
  end

  assign cmd_ready_o   = (state_q == IDLE) && run_q;
  assign wbm_cyc_o     = (state_q == BUS);
  assign wbm_stb_o     = (state_q == BUS);
  assign wbm_we_o      = we_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_dat_o     = (state_q == RESP) ? rdat_q : 32'h0;
  assign rsp_last_o    = (state_q == RESP) && rsp_last;
  assign rsp_timeout_o = (state_q == RESP) && tmo_q;

endmodule

// File: tb/tb_tdc_wb_master.sv
// Self-checking bench for tdc_wb_master: a behavioural Wishbone slave, a
// response consumer with optional stalls, and scoreboards for bus beats and
// responses filled when each command is issued.
module tb_tdc_wb_master;

  localparam int LEN_W = 4;
  localparam int TMO   = 64;

  typedef struct packed {
    logic [31:0] dat;
    logic        last;
    logic        tmo;
  } rsp_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0]      cmd_adr_i, cmd_dat_i;
  logic [3:0]       cmd_sel_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic             rsp_valid_o, rsp_ready_i, rsp_last_o, rsp_timeout_o;
  logic [31:0]      rsp_dat_o;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o, wbm_dat_o, wbm_dat_i;

  int n_tests = 0;
  int n_fail  = 0;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  // slave / consumer controls, written by the main sequence
  int  wait_st    = 0;
  bit  never_ack  = 1'b0;
  bit  stray_ack  = 1'b0;
  int  stall_beat = -1;
  int  stall_len  = 0;
  int  stall_done = 0;
  // monitor results
  int  stb_run    = 0;
  int  last_pulse = 0;
  int  pulses     = 0;
  int  rsp_cnt    = 0;
  bit  gap_pending = 1'b0;
  time accept_t   = 0;

  always #5 clk = ~clk;

  tdc_wb_master #(.LEN_W(LEN_W), .TIMEOUT_CYC(TMO)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_we_i      (cmd_we_i),
    .cmd_adr_i     (cmd_adr_i),
    .cmd_dat_i     (cmd_dat_i),
    .cmd_sel_i     (cmd_sel_i),
    .cmd_len_i     (cmd_len_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_dat_o     (rsp_dat_o),
    .rsp_last_o    (rsp_last_o),
    .rsp_timeout_o (rsp_timeout_o),
    .wbm_cyc_o     (wbm_cyc_o),
    .wbm_stb_o     (wbm_stb_o),
    .wbm_we_o      (wbm_we_o),
    .wbm_sel_o     (wbm_sel_o),
    .wbm_adr_o     (wbm_adr_o),
    .wbm_dat_o     (wbm_dat_o),
    .wbm_ack_i     (wbm_ack_i),
    .wbm_dat_i     (wbm_dat_i)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: acks after wait_st wait states with data adr^0x55; also measures
  // strobe pulses and checks each beat's address/controls and the beat gap.
  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      if (wbm_stb_o && wbm_cyc_o) begin
        stb_run++;
        if (stb_run == 1) begin
          if (bus_q.size() == 0) begin
            check("bus_unexpected", 1, 0);
          end else begin
            bus_t b;
            b = bus_q.pop_front();
            check("bus_adr", wbm_adr_o, b.adr);
            check("bus_ctl", {wbm_we_o, wbm_sel_o, wbm_dat_o}, {b.we, b.sel, b.dat});
          end
        end
      end else if (stb_run > 0) begin
        last_pulse = stb_run;
        pulses++;
        stb_run = 0;
      end
      if (gap_pending && $time > accept_t) begin
        check("beat_gap_stb", wbm_stb_o, 1'b1);
        gap_pending = 1'b0;
      end
      if (stray_ack || (wbm_stb_o && !never_ack && stb_run == wait_st + 1)) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = wbm_adr_o ^ 32'h55;
      end else begin
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'hDEAD_BEEF;
      end
    end
  end

  // Consumer: takes responses (stalling on a chosen beat) and scores them.
  initial begin
    rsp_t held;
    rsp_ready_i = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rsp_valid_o) begin
        rsp_ready_i = 1'b0;
      end else if (rsp_cnt == stall_beat && stall_done < stall_len) begin
        rsp_ready_i = 1'b0;
        if (stall_done == 0) held = {rsp_dat_o, rsp_last_o, rsp_timeout_o};
        else check("stall_hold", {rsp_dat_o, rsp_last_o, rsp_timeout_o}, held);
        check("stall_no_stb", wbm_stb_o, 1'b0);
        stall_done++;
      end else begin
        rsp_ready_i = 1'b1;
        rsp_cnt++;
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_dat", rsp_dat_o, e.dat);
          check("rsp_last_tmo", {rsp_last_o, rsp_timeout_o}, {e.last, e.tmo});
          if (!e.last) begin
            gap_pending = 1'b1;
            accept_t    = $time;
          end
        end
      end
    end
  end

  // Fills the scoreboards from a reference model of the command, then drives it.
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [LEN_W-1:0] len,
                          input bit expect_tmo, input bit push_rsp);
    int nb;
    nb = we ? 1 : int'(len) + 1;
    if (expect_tmo) nb = 1;
    for (int i = 0; i < nb; i++) begin
      bus_t  b;
      rsp_t  r;
      logic [31:0] a;
      a = adr + 32'(4 * i);
      b.we = we; b.sel = sel; b.adr = a; b.dat = we ? dat : 32'h0;
      bus_q.push_back(b);
      r.dat  = (we || expect_tmo) ? 32'h0 : (a ^ 32'h55);
      r.last = (i == nb - 1);
      r.tmo  = expect_tmo;
      if (push_rsp) rsp_q.push_back(r);
    end
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel; cmd_len_i = len;
    for (int k = 0; k < 100 && !cmd_ready_o; k++) @(negedge clk);
    if (!cmd_ready_o) check("cmd_accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (rsp_q.size() == 0 && cmd_ready_o) break;
    end
    check({tag, "_done"}, (k < 2000), 1'b1);
  endtask

  function automatic logic [127:0] all_outs();
    return {cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_last_o, rsp_timeout_o,
            wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o};
  endfunction

  initial begin
    int p0;
    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0;
    cmd_sel_i = '0; cmd_len_i = '0;

    // reset state
    #1 check("reset_outs", all_outs(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 check("ready_before_edge", cmd_ready_o, 1'b0);
    @(posedge clk); #1;
    check("ready_after_edge", cmd_ready_o, 1'b1);

    // single write, two wait states
    wait_st = 2; p0 = pulses;
    send_cmd(1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, '0, 1'b0, 1'b1);
    wait_done("write");
    check("write_pulse_len", last_pulse, 3);
    check("write_pulses", pulses - p0, 1);

    // four-beat read burst, zero wait states
    wait_st = 0; p0 = pulses;
    send_cmd(1'b0, 32'h3000_0010, 32'h1234_5678, 4'hF, 4'd3, 1'b0, 1'b1);
    wait_done("burst");
    check("burst_pulses", pulses - p0, 4);

    // backpressure on beat 2 of a 3-beat read
    stall_beat = rsp_cnt + 1; stall_len = 5; stall_done = 0;
    send_cmd(1'b0, 32'h3000_0100, 32'h0, 4'h3, 4'd2, 1'b0, 1'b1);
    wait_done("stall");
    check("stall_cycles", stall_done, 5);
    stall_beat = -1;

    // timeout: slave never acks
    never_ack = 1'b1; p0 = pulses;
    send_cmd(1'b0, 32'h3000_0200, 32'h0, 4'hF, 4'd2, 1'b1, 1'b1);
    wait_done("timeout");
    check("timeout_pulse_len", last_pulse, TMO);
    check("timeout_pulses", pulses - p0, 1);
    check("timeout_ready", cmd_ready_o, 1'b1);
    never_ack = 1'b0;

    // address wrap
    wait_st = 0;
    send_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 4'd1, 1'b0, 1'b1);
    wait_done("wrap");

    // ack in the cycle the counter hits the limit
    wait_st = TMO - 1;
    send_cmd(1'b0, 32'h3000_0300, 32'h0, 4'hF, 4'd0, 1'b0, 1'b1);
    wait_done("race");
    check("race_pulse_len", last_pulse, TMO);
    wait_st = 0;

    // stray ack while idle must not create a response
    p0 = rsp_cnt;
    stray_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stray_no_rsp", rsp_valid_o, 1'b0);
    end
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_rsp_cnt", rsp_cnt - p0, 0);

    // async reset in the 3rd BUS cycle
    never_ack = 1'b1; p0 = rsp_cnt;
    send_cmd(1'b0, 32'h3000_0400, 32'h0, 4'hF, 4'd1, 1'b1, 1'b0);
    // send_cmd returns at the negedge of the first BUS cycle
    repeat (2) @(negedge clk);
    check("pre_reset_stb", wbm_stb_o, 1'b1);
    rst = 1'b1;
    #1 check("async_reset_outs", all_outs(), '0);
    repeat (3) @(negedge clk);
    rst = 1'b0; never_ack = 1'b0; wait_st = 1;
    check("reset_no_rsp", rsp_cnt - p0, 0);
    send_cmd(1'b1, 32'h3000_0008, 32'h0BAD_F00D, 4'h5, '0, 1'b0, 1'b1);
    wait_done("post_reset");
    check("post_reset_pulse", last_pulse, 2);

    repeat (3) @(negedge clk);
    check("rsp_queue_empty", rsp_q.size(), 0);
    check("bus_queue_empty", bus_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
